// File: rtl/dac_pkg.sv
// Shared constants and types for the DAC SPI write path.
package dac_pkg;

  localparam int DAC_DATA_W  = 12;
  localparam int DAC_FRAME_W = 16;
  localparam int DAC_CMD_W   = 4;
  localparam int DAC_EDGE_W  = 5;

  localparam logic [DAC_CMD_W-1:0] DAC_DEFAULT_CMD = 4'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } dac_state_e;

  function automatic logic [DAC_FRAME_W-1:0] dac_frame(
    input logic [DAC_CMD_W-1:0]  cmd,
    input logic [DAC_DATA_W-1:0] code
  );
    return {cmd, code};
  endfunction

endpackage

// File: rtl/dac_sclk_tick.sv
// Down-counter that emits a one-cycle tick every DIV enabled clk cycles.
// While clr is high the counter is held at its reload value.
module dac_sclk_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= LOAD;
    end else if (en) begin
      if (cnt_q == '0) begin
        cnt_q <= LOAD;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/dac_spi_driver.sv
// Serializes {CMD, sample} as a 16-bit SPI mode-0 write frame, MSB first.
// Handshake: a sample is taken on a clk edge where sample_valid && sample_ready; otherwise it is ignored.
module dac_spi_driver
  import dac_pkg::*;
#(
  parameter int                   CLK_DIV    = 2,
  parameter int                   GAP_CYCLES = 2,
  parameter logic [DAC_CMD_W-1:0] CMD        = DAC_DEFAULT_CMD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAC_DATA_W-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  dac_cs_n,
  output logic                  dac_sclk,
  output logic                  dac_mosi,
  output logic                  busy,
  output dac_state_e            dbg_state
);

  // Ready is raised on the last gap cycle so the next handshake edge lands
  // exactly GAP_CYCLES after dac_cs_n rises; a one-cycle gap needs no GAP state.
  localparam bit GAP_SKIP = (GAP_CYCLES == 1);
  localparam int GAP_DIV  = GAP_SKIP ? 1 : GAP_CYCLES - 1;

  dac_state_e               state_q, state_d;
  logic                     sclk_q, sclk_d;
  logic                     cs_n_q, cs_n_d;
  logic                     mosi_q, mosi_d;
  logic                     ready_q, ready_d;
  logic [DAC_FRAME_W-1:0]   shreg_q, shreg_d;
  logic [DAC_EDGE_W-1:0]    fall_cnt_q, fall_cnt_d;
  logic                     sclk_tick;
  logic                     gap_tick;

  dac_sclk_tick #(.DIV(CLK_DIV)) u_sclk_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != SHIFT),
    .en   (state_q == SHIFT),
    .tick (sclk_tick)
  );

  dac_sclk_tick #(.DIV(GAP_DIV)) u_gap_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != GAP),
    .en   (state_q == GAP),
    .tick (gap_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b1;
      shreg_q    <= '0;
      fall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      shreg_q    <= shreg_d;
      fall_cnt_q <= fall_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    ready_d    = ready_q;
    shreg_d    = shreg_q;
    fall_cnt_d = fall_cnt_q;

    case (state_q)
      IDLE: begin
        if (sample_valid && ready_q) begin
          shreg_d    = dac_frame(CMD, sample_in);
          mosi_d     = CMD[DAC_CMD_W-1];
          cs_n_d     = 1'b0;
          sclk_d     = 1'b0;
          fall_cnt_d = '0;
          ready_d    = 1'b0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (sclk_tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d     = 1'b0;
            fall_cnt_d = fall_cnt_q + DAC_EDGE_W'(1);
            if (fall_cnt_q == DAC_EDGE_W'(DAC_FRAME_W - 1)) begin
              cs_n_d = 1'b1;
              mosi_d = 1'b0;
              if (GAP_SKIP) begin
                ready_d = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = GAP;
              end
            end else begin
              // Next lower bit appears on the falling edge, one half-period before the DAC samples it.
              mosi_d  = shreg_q[DAC_FRAME_W-2];
              shreg_d = {shreg_q[DAC_FRAME_W-2:0], 1'b0};
            end
          end
        end
      end

      GAP: begin
        if (gap_tick) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign sample_ready = ready_q;
  assign busy         = ~ready_q;
  assign dac_cs_n     = cs_n_q;
  assign dac_sclk     = sclk_q;
  assign dac_mosi     = mosi_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver: default instance (D=2, GAP=2) and minimum-divider instance (D=1, GAP=1).
module tb_dac_spi_driver;
  import dac_pkg::*;

  localparam int D0 = 2;
  localparam int G0 = 2;
  localparam int D1 = 1;
  localparam int G1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  vld;
  logic [11:0] sin [2];
  logic [1:0]  rdy, bsy, cs_n, sclk, mosi;
  dac_state_e  st0, st1;

  dac_spi_driver #(.CLK_DIV(D0), .GAP_CYCLES(G0), .CMD(4'h3)) u_dut0 (
    .clk(clk), .rst(rst[0]), .sample_in(sin[0]), .sample_valid(vld[0]),
    .sample_ready(rdy[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]),
    .dac_mosi(mosi[0]), .busy(bsy[0]), .dbg_state(st0)
  );

  dac_spi_driver #(.CLK_DIV(D1), .GAP_CYCLES(G1), .CMD(4'h3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .sample_in(sin[1]), .sample_valid(vld[1]),
    .sample_ready(rdy[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]),
    .dac_mosi(mosi[1]), .busy(bsy[1]), .dbg_state(st1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int dv(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int gp(input int i);
    return (i == 0) ? G0 : G1;
  endfunction

  // ---------------- behavioural model ----------------
  // Each frame is a timeline indexed by cycles since its handshake.
  int          cyc = 0;
  bit          act [2];
  int          t [2];
  logic [15:0] frm [2];
  bit          ab [2];
  int          hs_cnt [2];
  int          last_hs [2];
  int          prev_hs [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; t[i] = 0; frm[i] = '0; ab[i] = 0;
      hs_cnt[i] = 0; last_hs[i] = 0; prev_hs[i] = 0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      bit was_ready;
      if (rst[i]) begin
        if (act[i] && t[i] < 32 * dv(i)) ab[i] = 1;
        act[i] = 0;
        t[i]   = 0;
      end else begin
        was_ready = !act[i];
        if (act[i]) begin
          t[i]++;
          if (t[i] >= 32 * dv(i) + gp(i) - 1) act[i] = 0;
        end
        if (was_ready && vld[i]) begin
          act[i]     = 1;
          t[i]       = 0;
          frm[i]     = {4'h3, sin[i]};
          prev_hs[i] = last_hs[i];
          last_hs[i] = cyc;
          hs_cnt[i]++;
        end
      end
    end
  end

  // {ready, busy, cs_n, sclk, mosi}
  function automatic logic [4:0] expv(input int i);
    int ti;
    ti = t[i];
    if (!act[i]) return 5'b10100;
    if (ti < 32 * dv(i))
      return {1'b0, 1'b1, 1'b0, 1'((ti / dv(i)) % 2), frm[i][15 - ti / (2 * dv(i))]};
    return 5'b01100;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("outs_dut0", {27'd0, rdy[0], bsy[0], cs_n[0], sclk[0], mosi[0]}, {27'd0, expv(0)});
      check("outs_dut1", {27'd0, rdy[1], bsy[1], cs_n[1], sclk[1], mosi[1]}, {27'd0, expv(1)});
    end
  end

  // ---------------- scoreboard: frames seen by the DAC ----------------
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  logic [15:0] cap [2];
  int          nb [2];
  int          low_len [2];
  int          hi_len [2];
  int          last_hi [2];
  int          rises [2];
  logic        prev_cs [2];
  logic        prev_sclk [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      cap[i] = '0; nb[i] = 0; low_len[i] = 0; hi_len[i] = 0; last_hi[i] = 0;
      rises[i] = 0; prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        logic [15:0] want;
        if (sclk[i] && !prev_sclk[i]) begin
          rises[i]++;
          if (!cs_n[i]) begin
            cap[i] = {cap[i][14:0], mosi[i]};
            nb[i]++;
          end
        end
        if (!cs_n[i] && prev_cs[i]) begin
          last_hi[i] = hi_len[i];
          low_len[i] = 0;
        end
        if (cs_n[i] && !prev_cs[i]) begin
          if (ab[i]) begin
            ab[i] = 0;
          end else begin
            check((i == 0) ? "bits_dut0" : "bits_dut1", nb[i], 16);
            check((i == 0) ? "cs_low_dut0" : "cs_low_dut1", low_len[i], (i == 0) ? 64 : 32);
            if (((i == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
              n_chk++; n_fail++;
              $display("FAIL frame_unexpected dut%0d: got %0h expected none", i, cap[i]);
            end else begin
              want = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check((i == 0) ? "frame_dut0" : "frame_dut1", {16'd0, cap[i]}, {16'd0, want});
            end
          end
          cap[i]    = '0;
          nb[i]     = 0;
          hi_len[i] = 0;
        end
        if (!cs_n[i]) low_len[i]++;
        else          hi_len[i]++;
        prev_cs[i]   = cs_n[i];
        prev_sclk[i] = sclk[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_hs(input int i);
    int old;
    old = hs_cnt[i];
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (hs_cnt[i] != old) return;
    end
    n_chk++; n_fail++;
    $display("FAIL handshake_timeout dut%0d: got none expected one within 300 cycles", i);
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!act[i]) begin
        tick(2);
        return;
      end
    end
    n_chk++; n_fail++;
    $display("FAIL idle_timeout dut%0d: got busy expected idle within 300 cycles", i);
  endtask

  task automatic send(input int i, input logic [11:0] v);
    sin[i] = v;
    vld[i] = 1'b1;
    wait_hs(i);
    vld[i] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int r0;
    rst = 2'b11;
    vld = 2'b00;
    sin[0] = '0;
    sin[1] = '0;
    tick(1);
    started = 1;
    tick(2);
    check("reset_state_dut0", {27'd0, rdy[0], bsy[0], cs_n[0], sclk[0], mosi[0]}, 32'h14);
    check("reset_state_dut1", {27'd0, rdy[1], bsy[1], cs_n[1], sclk[1], mosi[1]}, 32'h14);
    rst = 2'b00;

    // idle quiescence
    r0 = rises[0];
    tick(200);
    check("idle_sclk_edges", rises[0] - r0, 0);

    // single frame
    exp_q0.push_back(16'h3ABC);
    send(0, 12'hABC);
    wait_idle(0);

    // back-to-back with valid held
    exp_q0.push_back(16'h3000);
    exp_q0.push_back(16'h3FFF);
    sin[0] = 12'h000;
    vld[0] = 1'b1;
    wait_hs(0);
    sin[0] = 12'hFFF;
    wait_hs(0);
    vld[0] = 1'b0;
    check("b2b_spacing", last_hs[0] - prev_hs[0], 66);
    tick(1);
    check("b2b_cs_gap", last_hi[0], 2);
    wait_idle(0);

    // back-pressure: new sample offered mid-frame must wait
    exp_q0.push_back(16'h3123);
    exp_q0.push_back(16'h3555);
    send(0, 12'h123);
    tick(9);
    sin[0] = 12'h555;
    vld[0] = 1'b1;
    wait_hs(0);
    vld[0] = 1'b0;
    check("bp_spacing", last_hs[0] - prev_hs[0], 66);
    wait_idle(0);

    // reset mid-frame aborts the frame
    send(0, 12'h9A5);
    tick(19);
    rst[0] = 1'b1;
    tick(1);
    check("abort_state", {27'd0, rdy[0], bsy[0], cs_n[0], sclk[0], mosi[0]}, 32'h14);
    rst[0] = 1'b0;
    r0 = rises[0];
    tick(20);
    check("abort_no_sclk", rises[0] - r0, 0);
    exp_q0.push_back(16'h3800);
    send(0, 12'h800);
    wait_idle(0);

    // minimum divider instance, two frames back to back
    exp_q1.push_back(16'h37E5);
    exp_q1.push_back(16'h37E5);
    sin[1] = 12'h7E5;
    vld[1] = 1'b1;
    wait_hs(1);
    wait_hs(1);
    vld[1] = 1'b0;
    check("min_div_spacing", last_hs[1] - prev_hs[1], 33);
    tick(1);
    check("min_div_cs_gap", last_hi[1], 1);
    wait_idle(1);

    tick(5);
    check("frames_left_dut0", exp_q0.size(), 0);
    check("frames_left_dut1", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
